lut_code_engine: RTL and testbench

//  Programmable, parametrised code converter that generalises our fixed 4-in/3-out logic maps.

---
 rtl/lut_code_engine_if.sv | 42 ++++
 rtl/lut_code_engine.sv | 140 ++++++++++++++
 tb/tb_lut_code_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_code_engine_if.sv
// Interface for lut_code_engine: config, lookup and sweep signal groups.
// The master side drives requests and config; the slave side is the engine itself.
interface lut_code_engine_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int SIG_W = 8
);
  logic             cfg_we;
  logic [IN_W-1:0]  cfg_addr;
  logic [OUT_W-1:0] cfg_data;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  logic             sweep_start;
  logic             sweep_busy;
  logic             sweep_done;
  logic [SIG_W-1:0] sweep_sig;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output in_valid, in_data,
    output out_ready,
    output sweep_start,
    input  in_ready, out_valid, out_data,
    input  sweep_busy, sweep_done, sweep_sig
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  in_valid, in_data,
    input  out_ready,
    input  sweep_start,
    output in_ready, out_valid, out_data,
    output sweep_busy, sweep_done, sweep_sig
  );
endinterface

// File: rtl/lut_code_engine.sv
// Programmable IN_W->OUT_W code converter backed by a register table, with a
// 1-cycle valid/ready lookup stage and a sweep mode that folds the table into a signature.
module lut_code_engine #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int SIG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  lut_code_engine_if.slave   bus
);

  localparam int              DEPTH   = 1 << IN_W;
  localparam logic [IN_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [OUT_W-1:0] r_table [DEPTH];
  logic [IN_W-1:0]  r_cnt;
  logic [SIG_W-1:0] r_sig;

  logic             r_out_vld_p1;
  logic [OUT_W-1:0] r_out_data_p1;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_start;
  logic             w_tab_we;

  // Rotate the running signature left by one and xor in the zero-extended entry.
  function automatic logic [SIG_W-1:0] sig_fold(
    input logic [SIG_W-1:0] sig,
    input logic [OUT_W-1:0] entry
  );
    logic [SIG_W-1:0] ext;
    logic [SIG_W-1:0] rot;
    ext              = '0;
    ext[OUT_W-1:0]   = entry;
    rot              = (sig << 1) | (sig >> (SIG_W - 1));
    return rot ^ ext;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sweep_start) begin
          w_state_nxt = SWEEP;
          w_start     = 1'b1;
        end
      end
      SWEEP: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_MAX) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The table is frozen while a sweep walks it so the signature reflects one snapshot.
  assign w_tab_we = bus.cfg_we & ~w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_tab_we) begin
      r_table[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sig <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_sig <= '0;
    end else if (w_busy) begin
      r_sig <= sig_fold(r_sig, r_table[r_cnt]);
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Lookups only start from IDLE; a held result may still drain during a sweep.
  assign w_in_ready = (r_state == IDLE) & (~r_out_vld_p1 | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // ---- stage p1: output register (reads the pre-write table entry) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
    end else if (w_accept) begin
      r_out_vld_p1  <= 1'b1;
      r_out_data_p1 <= r_table[bus.in_data];
    end else if (bus.out_ready) begin
      r_out_vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_vld_p1;
  assign bus.out_data   = r_out_data_p1;
  assign bus.sweep_busy = w_busy;
  assign bus.sweep_done = w_done;
  assign bus.sweep_sig  = r_sig;

endmodule

// File: tb/tb_lut_code_engine.sv
// Self-checking bench for lut_code_engine: directed scenarios plus randomized
// traffic and table contents checked against a table/slot reference model.
module tb_lut_code_engine;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int SIG_W = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  lut_code_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W)) bus ();

  lut_code_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [OUT_W-1:0] model_tab [DEPTH];

  // Signature: entry k ends up rotated left by (DEPTH-1-k) positions.
  function automatic logic [SIG_W-1:0] model_sig();
    logic [SIG_W-1:0] s;
    logic [2*SIG_W-1:0] w;
    int r;
    s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      r = (DEPTH - 1 - k) % SIG_W;
      w = {{SIG_W{1'b0}}, {(SIG_W-OUT_W){1'b0}}, model_tab[k]} << r;
      s = s ^ w[SIG_W-1:0] ^ w[2*SIG_W-1:SIG_W];
    end
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tab(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    cyc();
    bus.cfg_we   = 1'b0;
    model_tab[a] = d;
  endtask

  task automatic clear_tab();
    for (int k = 0; k < DEPTH; k++) write_tab(4'(k), 3'd0);
  endtask

  task automatic run_sweep(input logic inject, input logic [SIG_W-1:0] exp_sig, input string name);
    int   cnt;
    logic seen;
    cnt  = 0;
    seen = 1'b0;
    bus.sweep_start = 1'b1;
    cyc();
    bus.sweep_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.sweep_done) begin
        seen = 1'b1;
        break;
      end
      if (bus.sweep_busy) cnt++;
      bus.sweep_start = inject && (cnt == 3);
      bus.cfg_we      = inject && (cnt == 5);
      bus.cfg_addr    = 4'd5;
      bus.cfg_data    = ~model_tab[5];
      cyc();
    end
    bus.sweep_start = 1'b0;
    bus.cfg_we      = 1'b0;
    if (seen !== 1'b1) $display("FAIL %s_done: got %0d want 1", name, seen);
    else n_pass++;
    n_total++;
    if (cnt != 16) $display("FAIL %s_busy_cycles: got %0d want 16", name, cnt);
    else n_pass++;
    n_total++;
    if (bus.sweep_sig !== exp_sig) $display("FAIL %s_sig: got %0h want %0h", name, bus.sweep_sig, exp_sig);
    else n_pass++;
    n_total++;
    cyc();
    if (bus.sweep_done !== 1'b0 || bus.sweep_busy !== 1'b0)
      $display("FAIL %s_pulse_end: got done=%0b busy=%0b want 0 0", name, bus.sweep_done, bus.sweep_busy);
    else n_pass++;
    n_total++;
    if (bus.sweep_sig !== exp_sig) $display("FAIL %s_sig_hold: got %0h want %0h", name, bus.sweep_sig, exp_sig);
    else n_pass++;
    n_total++;
  endtask

  task automatic lookup_one(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] exp, input string name);
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
      $display("FAIL %s: got vld=%0b data=%0h want vld=1 data=%0h", name, bus.out_valid, bus.out_data, exp);
    else n_pass++;
    n_total++;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) model_tab[k] = '0;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.sweep_busy !== 1'b0 ||
        bus.sweep_done !== 1'b0 || bus.sweep_sig !== 8'h00)
      $display("FAIL reset_state: got vld=%0b data=%0h busy=%0b done=%0b sig=%0h want all 0",
               bus.out_valid, bus.out_data, bus.sweep_busy, bus.sweep_done, bus.sweep_sig);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_lookup_after_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'd9;
    bus.out_ready = 1'b0;
    #1;
    if (bus.in_ready !== 1'b1) $display("FAIL idle_ready: got %0b want 1", bus.in_ready);
    else n_pass++;
    n_total++;
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 3'd0)
      $display("FAIL lookup9_after_reset: got vld=%0b data=%0h want 1 0", bus.out_valid, bus.out_data);
    else n_pass++;
    n_total++;
    cyc();
    if (bus.out_valid !== 1'b0) $display("FAIL consume_clears_valid: got %0b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    run_sweep(1'b0, 8'h00, "sweep_reset_tab");
  endtask

  task automatic test_stream();
    int bad;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) write_tab(4'(k), 3'(k));
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(k);
      #1;
      if (bus.in_ready !== 1'b1) bad++;
      cyc();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 3'(k & 7)) begin
        $display("FAIL stream_k%0d: got vld=%0b data=%0h want 1 %0h", k, bus.out_valid, bus.out_data, k & 7);
      end else n_pass++;
      n_total++;
    end
    if (bad != 0) $display("FAIL stream_no_bubbles: got %0d stalls want 0", bad);
    else n_pass++;
    n_total++;
    bus.in_valid = 1'b0;
    cyc();
    if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got %0b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'd5;
    cyc();
    bus.in_data = 4'd6;
    #1;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_low: got %0b want 0", bus.in_ready);
    else n_pass++;
    n_total++;
    cyc();
    cyc();
    if (bus.out_valid !== 1'b1 || bus.out_data !== model_tab[5])
      $display("FAIL bp_hold: got vld=%0b data=%0h want 1 %0h", bus.out_valid, bus.out_data, model_tab[5]);
    else n_pass++;
    n_total++;
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_release: got %0b want 1", bus.in_ready);
    else n_pass++;
    n_total++;
    cyc();
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_data !== model_tab[6])
      $display("FAIL bp_next: got vld=%0b data=%0h want 1 %0h", bus.out_valid, bus.out_data, model_tab[6]);
    else n_pass++;
    n_total++;
    cyc();
    if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup: got %0b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_sweep_sig();
    clear_tab();
    write_tab(4'd15, 3'b101);
    run_sweep(1'b0, 8'h05, "sweep_t15");
    write_tab(4'd15, 3'b000);
    write_tab(4'd0, 3'b001);
    run_sweep(1'b0, 8'h80, "sweep_t0");
    for (int k = 0; k < DEPTH; k++) write_tab(4'(k), 3'($urandom_range(0, 7)));
    run_sweep(1'b0, model_sig(), "sweep_rand");
  endtask

  task automatic test_write_collision();
    write_tab(4'd3, 3'd2);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd3;
    bus.cfg_data  = 3'd6;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'd3;
    bus.out_ready = 1'b1;
    cyc();
    bus.cfg_we   = 1'b0;
    model_tab[3] = 3'd6;
    if (bus.out_data !== 3'd2) $display("FAIL collide_old: got %0h want 2", bus.out_data);
    else n_pass++;
    n_total++;
    cyc();
    bus.in_valid = 1'b0;
    if (bus.out_data !== 3'd6) $display("FAIL collide_new: got %0h want 6", bus.out_data);
    else n_pass++;
    n_total++;
    cyc();
  endtask

  task automatic test_sweep_ignores();
    // sweep_start and cfg_we are injected mid-sweep; neither may alter the outcome.
    logic [OUT_W-1:0] keep5;
    keep5 = model_tab[5];
    run_sweep(1'b1, model_sig(), "sweep_inject");
    lookup_one(4'd5, keep5, "sweep_cfg_ignored");
  endtask

  task automatic test_reset_mid_sweep();
    int   cnt;
    logic reached;
    logic bad;
    write_tab(4'd2, 3'd7);
    cnt     = 0;
    reached = 1'b0;
    bus.sweep_start = 1'b1;
    cyc();
    bus.sweep_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.sweep_busy) cnt++;
      if (cnt == 7) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        reached = 1'b1;
        break;
      end
      cyc();
    end
    for (int k = 0; k < DEPTH; k++) model_tab[k] = '0;
    if (reached !== 1'b1) $display("FAIL midsweep_reach: got %0b want 1", reached);
    else n_pass++;
    n_total++;
    if (bus.sweep_busy !== 1'b0 || bus.sweep_sig !== 8'h00 || bus.sweep_done !== 1'b0)
      $display("FAIL midsweep_abort: got busy=%0b sig=%0h done=%0b want 0 0 0",
               bus.sweep_busy, bus.sweep_sig, bus.sweep_done);
    else n_pass++;
    n_total++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sweep_done !== 1'b0) bad = 1'b1;
      cyc();
    end
    if (bad !== 1'b0) $display("FAIL midsweep_no_done: got %0b want 0", bad);
    else n_pass++;
    n_total++;
    lookup_one(4'd2, 3'd0, "midsweep_tab_cleared");
    run_sweep(1'b0, 8'h00, "sweep_after_abort");
  endtask

  task automatic test_random_traffic();
    logic             has;
    logic [OUT_W-1:0] val;
    logic             exp_ready;
    logic             acc;
    int               bad_rdy;
    int               bad_out;
    has     = 1'b0;
    val     = '0;
    bad_rdy = 0;
    bad_out = 0;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_addr  = ($urandom_range(0, 1) == 1) ? bus.in_data : 4'($urandom_range(0, 15));
      bus.cfg_data  = 3'($urandom_range(0, 7));
      #1;
      exp_ready = !has || bus.out_ready;
      if (bus.in_ready !== exp_ready) bad_rdy++;
      acc = bus.in_valid && exp_ready;
      if (acc) begin
        has = 1'b1;
        val = model_tab[bus.in_data];
      end else if (bus.out_ready) begin
        has = 1'b0;
      end
      if (bus.cfg_we) model_tab[bus.cfg_addr] = bus.cfg_data;
      cyc();
      if (bus.out_valid !== has || (has && bus.out_data !== val)) begin
        if (bad_out == 0)
          $display("FAIL rand_out_i%0d: got vld=%0b data=%0h want vld=%0b data=%0h",
                   i, bus.out_valid, bus.out_data, has, val);
        bad_out++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    if (bad_rdy != 0) $display("FAIL rand_ready: got %0d errors want 0", bad_rdy);
    else n_pass++;
    n_total++;
    if (bad_out != 0) $display("FAIL rand_out: got %0d errors want 0", bad_out);
    else n_pass++;
    n_total++;
    run_sweep(1'b0, model_sig(), "sweep_after_rand");
  endtask

  initial begin
    rst             = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    bus.sweep_start = 1'b0;
    test_reset();
    test_lookup_after_reset();
    test_stream();
    test_backpressure();
    test_sweep_sig();
    test_write_collision();
    test_sweep_ignores();
    test_reset_mid_sweep();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
